fifo_wr_arbiter: RTL and testbench
==================================

# fifo_wr_arbiter

Round-robin write-port arbiter for the asynchronous FIFO write domain. It shares the single FIFO write port among `NUM_REQ` producers, grants bounded bursts, and stalls on the write-side full flag. It drives `winc` and write data into the write-pointer/full logic and the FIFO memory, and consumes `wfull` and `half_full` from it.

## Interface
Parameters:
- `NUM_REQ`, 4: number of requesters, 2..16.
- `DATA_WIDTH`, 8: write data width.
- `BURST_MAX`, 4: maximum writes per grant, 1..255.

Ports:
- `wclk` input 1: write-domain clock; all logic on its rising edge.
- `wrst` input 1: reset, synchronous, active-high.
- `req` input `NUM_REQ`: per-requester write request; level, held while data is valid.
- `req_data` input `NUM_REQ*DATA_WIDTH`: requester i's data in bits `[i*DATA_WIDTH +: DATA_WIDTH]`.
- `wfull` input 1: FIFO full, from the write-pointer logic.
- `half_full` input 1: FIFO half-full indication, from the write-pointer logic.
- `gnt` output `NUM_REQ`: one-hot; bit i high means requester i's data is consumed this cycle.
- `winc` output 1: FIFO write enable.
- `wdata` output `DATA_WIDTH`: FIFO write data.
- `owner` output `$clog2(NUM_REQ)`: current burst owner; value is valid in BURST.
- `busy` output 1: state is BURST.
- `wr_total` output 16: saturating count of accepted writes.

## Operation
- FSM states:
  - IDLE: no owner.
  - BURST: owner fixed, writes flow.
- IDLE, any `req` high: pick the first requester at or above `rr_ptr`, searching upward and wrapping modulo `NUM_REQ`. Register it into `owner`, clear `burst_cnt`, go to BURST.
- IDLE, no requests: stay in IDLE. `wfull` does not block arbitration.
- BURST write condition: `req[owner] & ~wfull`. When true:
  - `winc`=1.
  - `gnt[owner]`=1.
  - `wdata` = `req_data` slice of `owner`.
  - `burst_cnt` and `wr_total` increment.
- `winc`, `gnt` and `wdata` are combinational from the registered state. They are forced to 0 whenever `wrst` is high.
- BURST with `wfull` high: no write, no grant. Stay in BURST and keep `owner` and `burst_cnt`.
- BURST exits to IDLE and sets `rr_ptr` to `(owner+1) mod NUM_REQ` when either:
  - the write at `burst_cnt == limit-1` occurs, or
  - `req[owner]` is low (no write that cycle).
- `limit` is `BURST_MAX`, except as noted under Configuration.
- `wr_total` stops at 16'hFFFF.
- `gnt` is never high without `winc`. At most one `gnt` bit is high. `winc` is never high while `wfull` is high.

## Timing
- Arbitration latency: a request seen in IDLE at edge N gives its first possible write in cycle N+1.
- Consecutive bursts are separated by exactly one IDLE cycle.
- Sustained throughput within a burst: one write per cycle while not full.
- A `wfull` rise blocks the write in the same cycle. The write-side full flag is registered, so the arbiter needs no extra margin.
- `req` dropping in the cycle after a grant is legal. The burst ends with no write in that cycle.
- Reset, when `wrst` is sampled high at an edge:
  - state = IDLE, `rr_ptr` = 0, `owner` = 0, `burst_cnt` = 0, `wr_total` = 0.
  - `busy` = 0; `gnt`, `winc` and `wdata` = 0.
  - A burst in progress is abandoned with no further writes.

## Configuration
- `FIFO_WR_ARB_THROTTLE_EN` defined:
  - `limit` is 1 while `half_full` is high; every grant is then a single write, followed by re-arbitration.
  - `half_full` is sampled per write. A burst with `burst_cnt` ≥ 1 ends on its next write once `half_full` rises.
- Not defined: `half_full` is ignored and `limit` is always `BURST_MAX`.

## Test plan
- Reset: assert `wrst` for 2 cycles with all `req` high. Required: `gnt`=0, `winc`=0, `wr_total`=0; first grant goes to requester 0 two cycles after `wrst` falls.
- Round robin: `NUM_REQ`=4, `BURST_MAX`=4, all `req` held high. Required: owners 0,1,2,3,0, 4 writes each, one idle cycle between bursts, `wr_total`=16 after 4 bursts.
- Full stall: hold `wfull` high for 5 cycles mid-burst after 2 writes. Required: no `winc`/`gnt` during the stall, owner kept, then 2 more writes and the burst ends.
- Early release: requester 2 drops `req` after 1 write. Required: burst ends, `rr_ptr`=3, next owner 3 if requesting.
- Throttle (macro defined): `half_full`=1 with requesters 0 and 1 active. Required: alternating single writes 0,1,0,1. Macro undefined: bursts of 4.
- Reset mid-burst: `wrst` high after 2 writes by owner 1. Required: `winc`=0 in that cycle, state IDLE, `rr_ptr`=0, `wr_total`=0.

Source files
------------

// File: rtl/fifo_wr_arbiter_if.sv
// fifo_wr_arbiter_if
// Bundles the signals between the FIFO write-port arbiter and its surroundings.
//   master : the arbiter. It receives req/req_data/wfull/half_full and drives
//            gnt/winc/wdata/owner/busy/wr_total.
//   slave  : producers plus the write-pointer logic (or a testbench). Each
//            signal has the opposite direction from the master side.
// Signals:
//   req       [NUM_REQ]             per-requester level request
//   req_data  [NUM_REQ*DATA_WIDTH]  requester i data at [i*DATA_WIDTH +: DATA_WIDTH]
//   wfull                           FIFO full (write domain, registered)
//   half_full                       FIFO half-full (write domain)
//   gnt       [NUM_REQ]             one-hot, data of requester consumed this cycle
//   winc                            FIFO write enable
//   wdata     [DATA_WIDTH]          FIFO write data
//   owner     [clog2(NUM_REQ)]      current burst owner
//   busy                            arbiter is in a burst
//   wr_total  [16]                  saturating count of accepted writes
interface fifo_wr_arbiter_if #(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 8
);
    localparam int OWNER_W = $clog2(NUM_REQ);

    logic [NUM_REQ-1:0]            req;
    logic [NUM_REQ*DATA_WIDTH-1:0] req_data;
    logic                          wfull;
    logic                          half_full;
    logic [NUM_REQ-1:0]            gnt;
    logic                          winc;
    logic [DATA_WIDTH-1:0]         wdata;
    logic [OWNER_W-1:0]            owner;
    logic                          busy;
    logic [15:0]                   wr_total;

    modport master (
        input  req, req_data, wfull, half_full,
        output gnt, winc, wdata, owner, busy, wr_total
    );

    modport slave (
        output req, req_data, wfull, half_full,
        input  gnt, winc, wdata, owner, busy, wr_total
    );
endinterface

// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter
// This module is a round-robin arbiter for the single write port of the
// asynchronous FIFO. It gives one producer at a time a bounded burst of
// writes. Writes stall while wfull is high. Between two bursts there is
// always exactly one IDLE cycle, and the arbiter uses that cycle to pick the
// next owner.
//
// Ports:
//   wclk  : write-domain clock. All logic runs on its rising edge.
//   wrst  : synchronous, active-high reset. While wrst is high, winc, gnt and
//           wdata are also held at 0.
//   bus   : fifo_wr_arbiter_if.master. It carries the requests and data, the
//           wfull/half_full flags, and the grant/write/status outputs.
//
// Optional feature: when FIFO_WR_ARB_THROTTLE_EN is defined, half_full limits
// every burst to a single write. The default build ignores half_full.
//
// States:
//   S_IDLE  | no owner; arbitrate when any req is high
//   S_BURST | owner fixed; one write per cycle while req[owner] & ~wfull
module fifo_wr_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 8,
    parameter int BURST_MAX  = 4
) (
    input  logic                wclk,
    input  logic                wrst,
    fifo_wr_arbiter_if.master   bus
);
    localparam int OWNER_W = $clog2(NUM_REQ);

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_BURST = 1'b1
    } state_t;

    state_t               state_q, state_d;
    logic [OWNER_W-1:0]   rr_ptr, rr_ptr_d;
    logic [OWNER_W-1:0]   owner_q, owner_d;
    logic [OWNER_W-1:0]   pick;
    logic [OWNER_W-1:0]   owner_inc;
    logic [7:0]           burst_cnt, burst_cnt_d;
    logic [15:0]          wr_total_q, wr_total_d;
    logic [7:0]           limit_m1;
    logic                 any_req;
    logic                 write_ok;
    logic [NUM_REQ-1:0]   gnt_vec;
    logic [DATA_WIDTH-1:0] wdata_sel;

`ifdef FIFO_WR_ARB_THROTTLE_EN
    // half_full is re-evaluated on every write. The burst-end compare below
    // uses >=, so a burst that is already past its first write also ends on
    // its next write.
    assign limit_m1 = bus.half_full ? 8'd0 : 8'(BURST_MAX - 1);
`else
    logic unused_half_full;
    assign unused_half_full = bus.half_full;
    assign limit_m1 = 8'(BURST_MAX - 1);
`endif

    assign any_req   = |bus.req;
    assign owner_inc = (owner_q == OWNER_W'(NUM_REQ - 1)) ? '0 : owner_q + 1'b1;

    // Find the first requester at or above rr_ptr, wrapping around. The loop
    // runs from the farthest offset to the nearest, so the nearest request
    // found is the one that sticks.
    always_comb begin
        int idx;
        idx  = 0;
        pick = rr_ptr;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            idx = int'(rr_ptr) + k;
            if (idx >= NUM_REQ) begin
                idx = idx - NUM_REQ;
            end
            if (bus.req[idx]) begin
                pick = OWNER_W'(idx);
            end
        end
    end

    // wrst also gates the write path, so nothing is written during the reset
    // cycle even though state is only cleared at the next edge.
    assign write_ok = (state_q == S_BURST) && bus.req[owner_q] && !bus.wfull && !wrst;

    always_comb begin
        gnt_vec   = '0;
        wdata_sel = '0;
        if (write_ok) begin
            gnt_vec[owner_q] = 1'b1;
            wdata_sel        = bus.req_data[owner_q*DATA_WIDTH +: DATA_WIDTH];
        end
    end

    always_comb begin
        state_d     = state_q;
        rr_ptr_d    = rr_ptr;
        owner_d     = owner_q;
        burst_cnt_d = burst_cnt;
        wr_total_d  = wr_total_q;
        case (state_q)
            S_IDLE: begin
                if (any_req) begin
                    owner_d     = pick;
                    burst_cnt_d = '0;
                    state_d     = S_BURST;
                end
            end
            S_BURST: begin
                if (write_ok) begin
                    burst_cnt_d = burst_cnt + 8'd1;
                    if (wr_total_q != 16'hFFFF) begin
                        wr_total_d = wr_total_q + 16'd1;
                    end
                    if (burst_cnt >= limit_m1) begin
                        state_d  = S_IDLE;
                        rr_ptr_d = owner_inc;
                    end
                end else if (!bus.req[owner_q]) begin
                    // The owner has dropped out. A stall on wfull with req
                    // still held keeps the burst open.
                    state_d  = S_IDLE;
                    rr_ptr_d = owner_inc;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge wclk) begin
        if (wrst) begin
            state_q    <= S_IDLE;
            rr_ptr     <= '0;
            owner_q    <= '0;
            burst_cnt  <= '0;
            wr_total_q <= '0;
        end else begin
            state_q    <= state_d;
            rr_ptr     <= rr_ptr_d;
            owner_q    <= owner_d;
            burst_cnt  <= burst_cnt_d;
            wr_total_q <= wr_total_d;
        end
    end

    assign bus.gnt      = gnt_vec;
    assign bus.winc     = write_ok;
    assign bus.wdata    = wdata_sel;
    assign bus.owner    = owner_q;
    assign bus.busy     = (state_q == S_BURST);
    assign bus.wr_total = wr_total_q;
endmodule

// File: tb/tb_fifo_wr_arbiter.sv
module tb_fifo_wr_arbiter;
    localparam int NUM_REQ    = 4;
    localparam int DATA_WIDTH = 8;
    localparam int BURST_MAX  = 4;

    logic wclk = 1'b0;
    logic wrst;
    int   checks = 0;
    int   errors = 0;

    fifo_wr_arbiter_if #(.NUM_REQ(NUM_REQ), .DATA_WIDTH(DATA_WIDTH)) bus ();

    fifo_wr_arbiter #(
        .NUM_REQ   (NUM_REQ),
        .DATA_WIDTH(DATA_WIDTH),
        .BURST_MAX (BURST_MAX)
    ) dut (
        .wclk (wclk),
        .wrst (wrst),
        .bus  (bus.master)
    );

    always #5 wclk = ~wclk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge wclk);
        #1;
    endtask

    // One write cycle by owner o. Requester o supplies data 8'h11*(o+1).
    task automatic chk_write(input int o);
        logic [7:0] exp_data;
        exp_data = 8'(8'h11 * (o + 1));
        #1;
        chk("write_gnt",   32'(bus.gnt),   32'(1 << o));
        chk("write_winc",  32'(bus.winc),  32'd1);
        chk("write_owner", 32'(bus.owner), 32'(o));
        chk("write_wdata", 32'(bus.wdata), 32'(exp_data));
        chk("write_busy",  32'(bus.busy),  32'd1);
        tick();
    endtask

    task automatic chk_idle(input int exp_total);
        #1;
        chk("idle_busy",     32'(bus.busy),     32'd0);
        chk("idle_winc",     32'(bus.winc),     32'd0);
        chk("idle_gnt",      32'(bus.gnt),      32'd0);
        chk("idle_wr_total", 32'(bus.wr_total), 32'(exp_total));
        tick();
    endtask

    // Output invariants. Inputs change 1 ns after the rising edge, so they
    // are stable at the falling edge.
    always @(negedge wclk) begin
        if (wrst === 1'b0) begin
            checks++;
            assert (!(bus.winc && bus.wfull)) else begin
                errors++;
                $error("FAIL inv_winc_wfull observed=%0b expected=0", bus.winc);
            end
            checks++;
            assert (((bus.gnt & (bus.gnt - 1'b1)) == '0) && ((bus.gnt != '0) == bus.winc)) else begin
                errors++;
                $error("FAIL inv_gnt observed=%0h/%0b expected=onehot-with-winc", bus.gnt, bus.winc);
            end
        end
    end

    initial begin
        bus.req_data  = 32'h44_33_22_11;
        bus.req       = 4'b1111;
        bus.wfull     = 1'b0;
        bus.half_full = 1'b0;
        wrst          = 1'b1;

        // Reset for 2 cycles with every request high.
        tick();
        tick();
        chk("rst_gnt",      32'(bus.gnt),      32'd0);
        chk("rst_winc",     32'(bus.winc),     32'd0);
        chk("rst_wdata",    32'(bus.wdata),    32'd0);
        chk("rst_wr_total", 32'(bus.wr_total), 32'd0);
        chk("rst_busy",     32'(bus.busy),     32'd0);
        wrst = 1'b0;
        #1;
        chk("rst_rel_busy", 32'(bus.busy), 32'd0);
        tick();

        // Round robin with every request held: owners 0,1,2,3, each with a
        // burst of 4 and one idle cycle between bursts.
        for (int b = 0; b < 4; b++) begin
            for (int w = 0; w < BURST_MAX; w++) begin
                chk_write(b);
            end
            chk_idle(4 * (b + 1));
        end

        // The fifth burst wraps back to owner 0. It stalls on wfull after 2 writes.
        chk_write(0);
        chk_write(0);
        bus.wfull = 1'b1;
        for (int s = 0; s < 5; s++) begin
            #1;
            chk("stall_winc",  32'(bus.winc),  32'd0);
            chk("stall_gnt",   32'(bus.gnt),   32'd0);
            chk("stall_owner", 32'(bus.owner), 32'd0);
            chk("stall_busy",  32'(bus.busy),  32'd1);
            tick();
        end
        bus.wfull = 1'b0;
        chk_write(0);
        chk_write(0);
        // rr_ptr is now 1. Requester 1 drops out, so the next owner is 2.
        bus.req = 4'b1101;
        chk_idle(20);

        // Early release: requester 2 drops req after 1 write.
        chk_write(2);
        bus.req = 4'b1001;
        #1;
        chk("early_winc", 32'(bus.winc), 32'd0);
        chk("early_gnt",  32'(bus.gnt),  32'd0);
        chk("early_busy", 32'(bus.busy), 32'd1);
        tick();
        #1;
        chk("early_rr_ptr", 32'(dut.rr_ptr), 32'd3);
        chk_idle(21);
        chk_write(3);
        // Owner 3 drops out. rr_ptr becomes 0, and requester 1 is the only one left.
        bus.req = 4'b0010;
        #1;
        chk("rel3_winc", 32'(bus.winc), 32'd0);
        tick();
        #1;
        chk("rel3_rr_ptr", 32'(dut.rr_ptr), 32'd0);
        chk_idle(22);

        // Reset mid-burst after 2 writes by owner 1.
        chk_write(1);
        chk_write(1);
        #1;
        chk("pre_rst_total", 32'(bus.wr_total), 32'd24);
        wrst = 1'b1;
        #1;
        chk("mid_rst_winc",  32'(bus.winc),  32'd0);
        chk("mid_rst_gnt",   32'(bus.gnt),   32'd0);
        chk("mid_rst_wdata", 32'(bus.wdata), 32'd0);
        tick();
        wrst = 1'b0;
        #1;
        chk("mid_rst_busy",   32'(bus.busy),     32'd0);
        chk("mid_rst_rr_ptr", 32'(dut.rr_ptr),   32'd0);
        chk("mid_rst_total",  32'(bus.wr_total), 32'd0);
        chk("mid_rst_owner",  32'(bus.owner),    32'd0);

        // half_full with requesters 0 and 1 active.
        bus.req       = 4'b0011;
        bus.half_full = 1'b1;
        tick();
`ifdef FIFO_WR_ARB_THROTTLE_EN
        chk_write(0);
        chk_idle(1);
        chk_write(1);
        chk_idle(2);
        chk_write(0);
        chk_idle(3);
        chk_write(1);
        chk_idle(4);
`else
        for (int w = 0; w < BURST_MAX; w++) begin
            chk_write(0);
        end
        chk_idle(4);
        for (int w = 0; w < BURST_MAX; w++) begin
            chk_write(1);
        end
        chk_idle(8);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
